// File: rtl/sysbus_pkg.sv
// sysbus_pkg: size codes, FSM encoding and widths shared by the Sys* responder.
package sysbus_pkg;

    localparam logic [1:0] BYTE     = 2'd0;
    localparam logic [1:0] HALFWORD = 2'd1;
    localparam logic [1:0] WORD     = 2'd2;

    localparam int CNT_W = 4;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size code 3 is handled as a word.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lsb);
        if (size == BYTE)
            return 1'b0;
        if (size == HALFWORD)
            return lsb[0];
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/sys_mem_array.sv
// sys_mem_array: word storage with byte-enable synchronous write and
// combinational read on a single shared address.
module sys_mem_array
    import sysbus_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [3:0]      i_be,
    input  logic [AW-1:0]   i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_be[i])
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sys_mem_responder.sv
// sys_mem_responder: latency-programmable memory slave on the cache Sys* bus.
// Define SYSMEM_MISALIGN_CHECK_EN to reject misaligned accesses via SysErr.
module sys_mem_responder
    import sysbus_pkg::*;
#(
    parameter int DEPTH     = 16384,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SysStrobe,
    input  logic        SysRW,
    input  logic [15:0] SysAddress,
    input  logic [1:0]  LoadSelect,
    inout  wire  [31:0] SysData,
    output logic        SysReady,
`ifdef SYSMEM_MISALIGN_CHECK_EN
    output logic        SysErr,
`endif
    output logic        SysBusy
);

    localparam int AW = $clog2(DEPTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    logic [15:0]        r_addr;
    logic [1:0]         r_size;
    logic [31:0]        r_data;
    logic               r_ready;
    logic               r_busy;
    logic               r_oe;

    logic [CNT_W-1:0]   w_lat;
    logic               w_misalign;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_word;
    logic [31:0]        w_rdata;

    assign w_lat = SysRW ? CNT_W'(READ_LAT) : CNT_W'(WRITE_LAT);

`ifdef SYSMEM_MISALIGN_CHECK_EN
    assign w_misalign = misaligned(r_size, r_addr[1:0]);
    assign SysErr     = r_ready & w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // Commit lands on the edge that ends RESP.
    assign w_we = (r_state == ST_RESP) && !r_rw && !w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_data;
        w_rdata = w_word;
        unique case (r_size)
            BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_data[7:0]}};
                w_rdata = {24'h0, w_word[{r_addr[1:0], 3'b000} +: 8]};
            end
            HALFWORD: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_data[15:0]}};
                w_rdata = {16'h0, w_word[{r_addr[1], 4'b0000} +: 16]};
            end
            default: ;
        endcase
        if (w_misalign)
            w_rdata = '0;
    end

    sys_mem_array #(
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_be   (w_be),
        .i_addr (r_addr[AW+1:2]),
        .i_wdata(w_wdata),
        .o_rdata(w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_size  <= BYTE;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (SysStrobe) begin
                        r_rw   <= SysRW;
                        r_addr <= SysAddress;
                        r_size <= LoadSelect;
                        r_data <= SysData;
                        r_busy <= 1'b1;
                        r_cnt  <= w_lat;
                        if (w_lat == '0) begin
                            r_state <= ST_RESP;
                            r_ready <= 1'b1;
                            r_oe    <= SysRW;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                        r_oe    <= r_rw;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_oe    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SysReady = r_ready;
    assign SysBusy  = r_busy;
    assign SysData  = r_oe ? w_rdata : 32'bz;

endmodule

// File: tb/tb_sys_mem_responder.sv
// tb_sys_mem_responder: table vectors, hand-built corner sequences and a
// randomized run against a byte-addressed reference model.
module tb_sys_mem_responder;
    import sysbus_pkg::*;

    localparam int RL = 4;
    localparam int WL = 2;
    localparam logic [31:0] PAT = 32'hA5C3_5A3C;
`ifdef SYSMEM_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        bit          rw;
        logic [15:0] a;
        logic [1:0]  sz;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        SysStrobe;
    logic        SysRW;
    logic [15:0] SysAddress;
    logic [1:0]  LoadSelect;
    wire  [31:0] SysData;
    logic        SysReady;
    logic        SysBusy;
    logic        err_w;
    logic        tb_oe;
    logic [31:0] tb_dat;

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [int];
    vec_t tbl [13];

    assign SysData = tb_oe ? tb_dat : 32'bz;
    always #5 clk = ~clk;

    sys_mem_responder #(
        .DEPTH     (16384),
        .READ_LAT  (RL),
        .WRITE_LAT (WL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SysStrobe (SysStrobe),
        .SysRW     (SysRW),
        .SysAddress(SysAddress),
        .LoadSelect(LoadSelect),
        .SysData   (SysData),
        .SysReady  (SysReady),
`ifdef SYSMEM_MISALIGN_CHECK_EN
        .SysErr    (err_w),
`endif
        .SysBusy   (SysBusy)
    );

`ifndef SYSMEM_MISALIGN_CHECK_EN
    assign err_w = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit mis(input logic [15:0] a, input logic [1:0] sz);
        return (int'(a) % nbytes(sz)) != 0;
    endfunction

    task automatic mdl_write(input logic [15:0] a, input logic [1:0] sz,
                             input logic [31:0] d);
        int n, base;
        n = nbytes(sz);
        if (CHK && mis(a, sz))
            return;
        base = int'(a) - (int'(a) % n);
        for (int i = 0; i < n; i++)
            mb[base + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] mdl_read(input logic [15:0] a,
                                             input logic [1:0] sz);
        int n, base;
        logic [31:0] v;
        n = nbytes(sz);
        v = '0;
        if (CHK && mis(a, sz))
            return v;
        base = int'(a) - (int'(a) % n);
        for (int i = 0; i < n; i++)
            v = v | (32'(mb[base + i]) << (8 * i));
        return v;
    endfunction

    task automatic xfer(input bit rw, input logic [15:0] a,
                        input logic [1:0] sz, input logic [31:0] d,
                        input bit poke, output logic [31:0] rd);
        int lat, k;
        lat = rw ? RL : WL;
        @(negedge clk);
        SysRW = rw; SysAddress = a; LoadSelect = sz;
        tb_dat = d; tb_oe = 1'b1; SysStrobe = 1'b1;
        @(posedge clk); #1;
        SysStrobe = 1'b0; SysAddress = ~a; tb_dat = ~d; tb_oe = !rw;
        k = 0;
        while (SysReady !== 1'b1 && k < lat + 3) begin
            chk("busy_wait", 32'(SysBusy), 32'd1);
            if (poke && k == 1) begin
                SysStrobe = 1'b1; SysRW = 1'b0; SysAddress = a;
                tb_oe = 1'b1; tb_dat = 32'h0;
            end
            @(posedge clk); #1;
            k++;
            if (poke && k == 2) begin
                SysStrobe = 1'b0; tb_oe = !rw;
            end
        end
        chk("latency", k, lat);
        chk("busy_resp", 32'(SysBusy), 32'd1);
        chk("err_flag", 32'(err_w), 32'(CHK && mis(a, sz)));
        rd = SysData;
        @(posedge clk); #1;
        chk("ready_drop", 32'(SysReady), 32'd0);
        chk("busy_drop", 32'(SysBusy), 32'd0);
        tb_oe = 1'b1; tb_dat = PAT;
        #1;
        chk("bus_release", SysData, PAT);
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] a;
        logic [1:0]  sz;
        logic [31:0] d;
        bit          rw;

        tbl[0]  = '{1'b0, 16'h0010, WORD,     32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 16'h0010, WORD,     32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b0, 16'h0012, BYTE,     32'h000000AA, 32'h0};
        tbl[3]  = '{1'b1, 16'h0010, WORD,     32'h0,        32'hDEAABEEF};
        tbl[4]  = '{1'b1, 16'h0013, BYTE,     32'h0,        32'h000000DE};
        tbl[5]  = '{1'b0, 16'h0012, HALFWORD, 32'h00001234, 32'h0};
        tbl[6]  = '{1'b1, 16'h0012, HALFWORD, 32'h0,        32'h00001234};
        tbl[7]  = '{1'b1, 16'h0010, WORD,     32'h0,        32'h1234BEEF};
        tbl[8]  = '{1'b1, 16'h0010, 2'd3,     32'h0,        32'h1234BEEF};
        tbl[9]  = '{1'b1, 16'h0010, BYTE,     32'h0,        32'h000000EF};
        tbl[10] = '{1'b1, 16'h0010, HALFWORD, 32'h0,        32'h0000BEEF};
        tbl[11] = '{1'b0, 16'h0010, BYTE,     32'hFFFFFF01, 32'h0};
        tbl[12] = '{1'b1, 16'h0010, WORD,     32'h0,        32'h1234BE01};

        rst = 1'b1; SysStrobe = 1'b0; SysRW = 1'b0;
        SysAddress = '0; LoadSelect = '0;
        tb_oe = 1'b1; tb_dat = PAT;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(SysReady), 32'd0);
        chk("rst_busy", 32'(SysBusy), 32'd0);
        chk("rst_err", 32'(err_w), 32'd0);
        chk("rst_bus", SysData, PAT);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            xfer(tbl[i].rw, tbl[i].a, tbl[i].sz, tbl[i].d, 1'b0, rd);
            if (tbl[i].rw)
                chk($sformatf("tbl_rd%0d", i), rd, tbl[i].exp);
            else
                mdl_write(tbl[i].a, tbl[i].sz, tbl[i].d);
        end

        // Strobe (a write of zero) during a read's WAIT must be dropped.
        xfer(1'b1, 16'h0010, WORD, 32'h0, 1'b1, rd);
        chk("poke_rd", rd, 32'h1234BE01);
        repeat (4) begin
            @(posedge clk); #1;
            chk("poke_no_ready", 32'(SysReady), 32'd0);
            chk("poke_no_busy", 32'(SysBusy), 32'd0);
        end
        xfer(1'b1, 16'h0010, WORD, 32'h0, 1'b0, rd);
        chk("poke_no_write", rd, 32'h1234BE01);

        // Reset during a write's WAIT aborts it.
        @(negedge clk);
        SysRW = 1'b0; SysAddress = 16'h0010; LoadSelect = WORD;
        tb_dat = 32'h0; SysStrobe = 1'b1;
        @(posedge clk); #1;
        SysStrobe = 1'b0; tb_dat = PAT;
        chk("abort_busy_pre", 32'(SysBusy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(SysBusy), 32'd0);
        chk("abort_ready", 32'(SysReady), 32'd0);
        chk("abort_bus", SysData, PAT);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b1, 16'h0010, WORD, 32'h0, 1'b0, rd);
        chk("abort_no_write", rd, 32'h1234BE01);

        // Misaligned word write and halfword read.
        xfer(1'b0, 16'h0011, WORD, 32'hCAFEF00D, 1'b0, rd);
        mdl_write(16'h0011, WORD, 32'hCAFEF00D);
        xfer(1'b1, 16'h0010, WORD, 32'h0, 1'b0, rd);
        chk("mis_wr", rd, CHK ? 32'h1234BE01 : 32'hCAFEF00D);
        xfer(1'b1, 16'h0011, HALFWORD, 32'h0, 1'b0, rd);
        chk("mis_rd", rd, CHK ? 32'h0 : 32'h0000F00D);

        for (int w = 0; w < 32; w++) begin
            a = (w < 16) ? 16'(w * 4) : 16'(16'hFFC0 + (w - 16) * 4);
            d = $urandom;
            xfer(1'b0, a, WORD, d, 1'b0, rd);
            mdl_write(a, WORD, d);
        end

        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                a = a + 16'hFFC0;
            d  = $urandom;
            xfer(rw, a, sz, d, 1'b0, rd);
            if (rw)
                chk($sformatf("rnd_rd a=%h sz=%0d", a, sz), rd, mdl_read(a, sz));
            else
                mdl_write(a, sz, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
